// File: rtl/unidade_controle_jogo_if.sv
// unidade_controle_jogo_if: control/status signals between the game controller and its datapath
//   master: datapath/bench side (drives iniciar, jogada, igual, fimC)
//   slave : controller side (drives zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout, db_estado)
interface unidade_controle_jogo_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;
    modport master (
        output iniciar, jogada, igual, fimC,
        input  zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout, db_estado
    );
    modport slave (
        input  iniciar, jogada, igual, fimC,
        output zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing a memory game with a per-play timeout
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : iniciar/jogada/igual/fimC in; counter/register controls, result flags, db_estado out
module unidade_controle_jogo #(
    parameter int TIMEOUT = 3000
) (
    input logic                   clock,
    input logic                   reset,
    unidade_controle_jogo_if.slave bus
);
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hD
    } estado_t;

    localparam int             TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:     estado_d = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  estado_d = ESPERA;
            // jogada takes priority over an expiring timer
            ESPERA:      estado_d = bus.jogada ? REGISTRA : (timer_q == TMAX) ? FIM_TIMEOUT : ESPERA;
            REGISTRA:    estado_d = COMPARACAO;
            COMPARACAO:  estado_d = !bus.igual ? FIM_ERROU : bus.fimC ? FIM_ACERTOU : PROXIMO;
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTOU: estado_d = bus.iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   estado_d = bus.iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT: estado_d = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     estado_d = INICIAL;
        endcase
        // staying in ESPERA implies timer_q < TMAX, so the increment never wraps
        timer_d = (estado_q == ESPERA && estado_d == ESPERA) ? timer_q + 1'b1 : '0;
    end

    assign bus.zeraC     = estado_q == PREPARACAO;
    assign bus.zeraR     = estado_q == PREPARACAO;
    assign bus.registraR = estado_q == REGISTRA;
    assign bus.contaC    = estado_q == PROXIMO;
    assign bus.acertou   = estado_q == FIM_ACERTOU;
    assign bus.errou     = estado_q == FIM_ERROU || estado_q == FIM_TIMEOUT;
    assign bus.timeout   = estado_q == FIM_TIMEOUT;
    assign bus.pronto    = estado_q == FIM_ACERTOU || estado_q == FIM_ERROU || estado_q == FIM_TIMEOUT;
    assign bus.db_estado = estado_q;
endmodule
